// File: rtl/capsense_poll_sched.sv
// Cap-sense poll scheduler: periodic status polls round-robin with host writes over one I2C engine, plus button debounce.
// Optional interrupt output enabled by defining CAPSENSE_IRQ_EN.
module capsense_poll_sched #(
    parameter int unsigned POLL_DIV     = 500000,
    parameter int unsigned DEBOUNCE_CNT = 3,
    parameter logic [7:0]  STATUS_REG   = 8'h03,
    parameter int unsigned TIMEOUT_CYC  = 1000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       low_active,
    input  logic       cfg_req,
    input  logic [7:0] cfg_reg,
    input  logic [7:0] cfg_wdata,
    output logic       cfg_done,
    output logic       cfg_err,
    output logic       txn_req,
    output logic       txn_rw,
    output logic [7:0] txn_reg,
    output logic [7:0] txn_wdata,
    input  logic       txn_ack,
    input  logic       txn_done,
    input  logic       txn_nack,
    input  logic [7:0] txn_rdata,
    output logic       button_0,
    output logic       button_1,
    output logic [1:0] btn_press,
    output logic [1:0] btn_release,
`ifdef CAPSENSE_IRQ_EN
    input  logic [1:0] irq_mask,
    input  logic       irq_clr,
    output logic       irq,
`endif
    output logic       poll_overrun,
    output logic       poll_err
);

    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state;
    logic [23:0]     poll_timer;
    logic            tick;
    logic            poll_pend;
    logic            last_cfg;
    logic            owner_poll;
    logic [WW-1:0]   wdog;
    logic [1:0]      btn_q;
    logic [1:0][3:0] db_cnt;

    logic            grant_poll;
    logic            grant_cfg;
    logic            finish;
    logic            fail;
    logic [1:0]      sample;
    logic [1:0][3:0] db_cnt_nx;
    logic [1:0]      btn_nx;
    logic [1:0]      press_nx;
    logic [1:0]      release_nx;
    logic            rdata_unused;

    assign tick         = (poll_timer == 24'(POLL_DIV - 1));
    assign grant_poll   = (state == IDLE) && (poll_pend || tick) && (!cfg_req || last_cfg);
    assign grant_cfg    = (state == IDLE) && cfg_req && !grant_poll;
    assign finish       = txn_done || (wdog == WW'(TIMEOUT_CYC - 1));
    assign fail         = txn_done ? txn_nack : 1'b1;
    assign sample       = txn_rdata[1:0] ^ {2{low_active}};
    assign rdata_unused = ^txn_rdata[7:2];
    assign button_0     = btn_q[0];
    assign button_1     = btn_q[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            poll_timer   <= '0;
            poll_pend    <= 1'b0;
            poll_overrun <= 1'b0;
        end else begin
            poll_timer <= tick ? 24'd0 : poll_timer + 24'd1;
            if (grant_poll)
                poll_pend <= 1'b0;
            else if (tick)
                poll_pend <= 1'b1;
            // Only one poll is ever queued; a tick that finds one waiting is just flagged.
            if (tick && poll_pend)
                poll_overrun <= 1'b1;
        end
    end

    always_comb begin
        db_cnt_nx  = db_cnt;
        btn_nx     = btn_q;
        press_nx   = 2'b00;
        release_nx = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (sample[i] == btn_q[i]) begin
                db_cnt_nx[i] = 4'd0;
            end else if (db_cnt[i] == 4'(DEBOUNCE_CNT - 1)) begin
                btn_nx[i]     = ~btn_q[i];
                press_nx[i]   = ~btn_q[i];
                release_nx[i] = btn_q[i];
                db_cnt_nx[i]  = 4'd0;
            end else begin
                db_cnt_nx[i] = db_cnt[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            txn_req     <= 1'b0;
            txn_rw      <= 1'b0;
            txn_reg     <= 8'h00;
            txn_wdata   <= 8'h00;
            owner_poll  <= 1'b0;
            last_cfg    <= 1'b1;
            wdog        <= '0;
            cfg_done    <= 1'b0;
            cfg_err     <= 1'b0;
            poll_err    <= 1'b0;
            btn_q       <= 2'b00;
            db_cnt      <= '0;
            btn_press   <= 2'b00;
            btn_release <= 2'b00;
        end else begin
            cfg_done    <= 1'b0;
            cfg_err     <= 1'b0;
            btn_press   <= 2'b00;
            btn_release <= 2'b00;
            case (state)
                IDLE: begin
                    if (grant_poll) begin
                        owner_poll <= 1'b1;
                        last_cfg   <= 1'b0;
                        txn_rw     <= 1'b1;
                        txn_reg    <= STATUS_REG;
                        txn_wdata  <= 8'h00;
                        txn_req    <= 1'b1;
                        state      <= ISSUE;
                    end else if (grant_cfg) begin
                        owner_poll <= 1'b0;
                        last_cfg   <= 1'b1;
                        txn_rw     <= 1'b0;
                        txn_reg    <= cfg_reg;
                        txn_wdata  <= cfg_wdata;
                        txn_req    <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (txn_ack) begin
                        txn_req <= 1'b0;
                        wdog    <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    // Completion is reported on entry to DONE so cfg_done precedes the next IDLE cycle.
                    if (finish) begin
                        state <= DONE;
                        if (owner_poll) begin
                            if (fail) begin
                                poll_err <= 1'b1;
                            end else begin
                                btn_q       <= btn_nx;
                                db_cnt      <= db_cnt_nx;
                                btn_press   <= press_nx;
                                btn_release <= release_nx;
                            end
                        end else begin
                            cfg_done <= 1'b1;
                            cfg_err  <= fail;
                        end
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CAPSENSE_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            irq <= 1'b0;
        else if (|((btn_press | btn_release) & irq_mask))
            irq <= 1'b1;
        else if (irq_clr)
            irq <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_capsense_poll_sched.sv
// Directed bench for capsense_poll_sched with a behavioural I2C engine (POLL_DIV=100, TIMEOUT_CYC=50).
`timescale 1ns/1ps
module tb_capsense_poll_sched;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       low_active = 1'b0;
    logic       cfg_req = 1'b0;
    logic [7:0] cfg_reg = 8'h00;
    logic [7:0] cfg_wdata = 8'h00;
    logic       cfg_done, cfg_err, txn_req, txn_rw;
    logic [7:0] txn_reg, txn_wdata;
    logic       txn_ack, txn_done, txn_nack;
    logic [7:0] txn_rdata;
    logic       button_0, button_1, poll_overrun, poll_err;
    logic [1:0] btn_press, btn_release;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;
    int press_cnt = 0;

    int         eng_ack_delay = 0;
    int         eng_done_delay = 1;
    logic [7:0] eng_rdata = 8'h01;
    logic       eng_nack = 1'b0;
    logic       eng_hang = 1'b0;
    int         eng_state = 0;
    int         eng_cnt = 0;
    logic       cur_hang = 1'b0;
    logic       cur_rw = 1'b0;
    int         poll_done_cnt = 0;
    logic       log_rw[$];
    logic [7:0] log_reg[$];
    logic [7:0] log_wd[$];
    int         log_cyc[$];

    always #5 clk = ~clk;

    capsense_poll_sched #(
        .POLL_DIV(100), .DEBOUNCE_CNT(3), .STATUS_REG(8'h03), .TIMEOUT_CYC(50)
    ) dut (
        .clk(clk), .reset_n(reset_n), .low_active(low_active),
        .cfg_req(cfg_req), .cfg_reg(cfg_reg), .cfg_wdata(cfg_wdata),
        .cfg_done(cfg_done), .cfg_err(cfg_err),
        .txn_req(txn_req), .txn_rw(txn_rw), .txn_reg(txn_reg), .txn_wdata(txn_wdata),
        .txn_ack(txn_ack), .txn_done(txn_done), .txn_nack(txn_nack), .txn_rdata(txn_rdata),
        .button_0(button_0), .button_1(button_1),
        .btn_press(btn_press), .btn_release(btn_release),
        .poll_overrun(poll_overrun), .poll_err(poll_err)
    );

    always @(posedge clk or negedge reset_n)
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;

    always @(negedge clk)
        if (btn_press[0]) press_cnt = press_cnt + 1;

    // Engine model: acks after eng_ack_delay cycles, finishes eng_done_delay cycles later unless hung.
    initial begin : engine
        txn_ack = 1'b0; txn_done = 1'b0; txn_nack = 1'b0; txn_rdata = 8'h00;
        forever begin
            @(negedge clk);
            txn_ack = 1'b0; txn_done = 1'b0; txn_nack = 1'b0;
            if (!reset_n) begin
                eng_state = 0;
                eng_cnt = 0;
            end else if (eng_state == 0) begin
                if (txn_req) begin
                    if (eng_cnt >= eng_ack_delay) begin
                        txn_ack = 1'b1;
                        eng_state = 1;
                        eng_cnt = 0;
                        cur_hang = eng_hang;
                        cur_rw = txn_rw;
                        log_rw.push_back(txn_rw);
                        log_reg.push_back(txn_reg);
                        log_wd.push_back(txn_wdata);
                        log_cyc.push_back(cyc);
                    end else begin
                        eng_cnt++;
                    end
                end
            end else if (cur_hang) begin
                if (txn_req) eng_state = 0;
            end else if (eng_cnt + 1 >= eng_done_delay) begin
                txn_done = 1'b1;
                txn_nack = eng_nack;
                txn_rdata = eng_rdata;
                eng_state = 0;
                eng_cnt = 0;
                if (cur_rw) poll_done_cnt++;
            end else begin
                eng_cnt++;
            end
        end
    end

    task automatic wait_polls(input int target);
        for (int n = 0; n < 300 && poll_done_cnt < target; n++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({txn_req, txn_rw, txn_reg, txn_wdata, cfg_done, cfg_err, button_0, button_1,
             btn_press, btn_release, poll_overrun, poll_err} !== 31'd0) begin
            n_err++; $display("[TB] FAIL reset_outputs: got nonzero outputs, required all 0");
        end
        reset_n = 1'b1;
    endtask

    task automatic test_first_poll();
        for (int n = 0; n < 150 && !txn_req; n++) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if (cyc !== 100) begin
            n_err++; $display("[TB] FAIL first_req_cycle: got %0d required 100", cyc);
        end
        n_cmp++;
        if ({txn_rw, txn_reg} !== {1'b1, 8'h03}) begin
            n_err++; $display("[TB] FAIL first_req_fields: got rw=%0b reg=%h required rw=1 reg=03", txn_rw, txn_reg);
        end
        for (int n = 0; n < 400 && !button_0; n++) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if (poll_done_cnt !== 3) begin
            n_err++; $display("[TB] FAIL rise_poll_count: got %0d required 3", poll_done_cnt);
        end
        n_cmp++;
        if ({button_0, button_1, btn_press, btn_release} !== 6'b10_01_00) begin
            n_err++; $display("[TB] FAIL rise_pulse: got b0=%0b b1=%0b press=%b rel=%b required 1 0 01 00",
                              button_0, button_1, btn_press, btn_release);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (btn_press !== 2'b00) begin
            n_err++; $display("[TB] FAIL press_one_cycle: got %b required 00", btn_press);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        int dones = 0;
        for (int n = 0; n < 200 && !(txn_req && txn_rw); n++) begin
            @(posedge clk); #1;
        end
        // Hold the poll in ISSUE past the next tick so both requesters are pending afterwards.
        base = log_rw.size();
        eng_ack_delay = 110;
        cfg_reg = 8'h10; cfg_wdata = 8'hA5; cfg_req = 1'b1;
        for (int n = 0; n < 400 && dones < 2; n++) begin
            @(posedge clk); #1;
            if (log_rw.size() > base) eng_ack_delay = 0;
            if (cfg_done) begin
                dones++;
                n_cmp++;
                if (cfg_err !== 1'b0) begin
                    n_err++; $display("[TB] FAIL b2b_cfg_err: got %0b required 0", cfg_err);
                end
                if (dones == 2) cfg_req = 1'b0;
            end
        end
        cfg_req = 1'b0;
        n_cmp++;
        if (dones !== 2 || log_rw.size() < base + 4) begin
            n_err++; $display("[TB] FAIL b2b_count: got %0d dones %0d grants required 2 and 4", dones, log_rw.size() - base);
        end else begin
            n_cmp++;
            if ({log_rw[base], log_rw[base+1], log_rw[base+2], log_rw[base+3]} !== 4'b1010) begin
                n_err++; $display("[TB] FAIL b2b_order: got %b%b%b%b required 1010",
                                  log_rw[base], log_rw[base+1], log_rw[base+2], log_rw[base+3]);
            end
            n_cmp++;
            if ({log_reg[base+1], log_wd[base+1], log_reg[base+2], log_reg[base+3], log_wd[base+3]}
                    !== {8'h10, 8'hA5, 8'h03, 8'h10, 8'hA5}) begin
                n_err++; $display("[TB] FAIL b2b_fields: got %h %h %h %h %h required 10 a5 03 10 a5",
                                  log_reg[base+1], log_wd[base+1], log_reg[base+2], log_reg[base+3], log_wd[base+3]);
            end
        end
    endtask

    task automatic test_poll_nack();
        int base = poll_done_cnt;
        eng_rdata = 8'h00;
        wait_polls(base + 1);
        n_cmp++;
        if ({poll_done_cnt == base + 1, poll_err, button_0} !== 3'b101) begin
            n_err++; $display("[TB] FAIL nack_pre: got err=%0b b0=%0b polls=%0d required err=0 b0=1", poll_err, button_0, poll_done_cnt - base);
        end
        eng_nack = 1'b1;
        wait_polls(base + 2);
        eng_nack = 1'b0;
        n_cmp++;
        if ({poll_err, button_0} !== 2'b11) begin
            n_err++; $display("[TB] FAIL nack_flag: got err=%0b b0=%0b required err=1 b0=1", poll_err, button_0);
        end
        // A NACKed poll must not advance the count: the fall needs two more good polls.
        wait_polls(base + 3);
        n_cmp++;
        if (button_0 !== 1'b1) begin
            n_err++; $display("[TB] FAIL nack_hold: got b0=%0b required 1", button_0);
        end
        wait_polls(base + 4);
        n_cmp++;
        if ({poll_done_cnt == base + 4, button_0, btn_release} !== 4'b1_0_01) begin
            n_err++; $display("[TB] FAIL nack_fall: got b0=%0b rel=%b polls=%0d required b0=0 rel=01 polls=4",
                              button_0, btn_release, poll_done_cnt - base);
        end
    endtask

    task automatic test_timeout();
        int base = log_rw.size();
        int done_cyc = -1;
        eng_hang = 1'b1;
        cfg_reg = 8'h20; cfg_wdata = 8'h5A; cfg_req = 1'b1;
        for (int n = 0; n < 200 && done_cyc < 0; n++) begin
            @(posedge clk); #1;
            if (log_rw.size() > base) eng_hang = 1'b0;
            if (cfg_done) begin
                done_cyc = cyc;
                cfg_req = 1'b0;
                n_cmp++;
                if ({cfg_err, txn_req} !== 2'b10) begin
                    n_err++; $display("[TB] FAIL timeout_err: got err=%0b req=%0b required err=1 req=0", cfg_err, txn_req);
                end
            end
        end
        cfg_req = 1'b0;
        eng_hang = 1'b0;
        n_cmp++;
        if (done_cyc < 0 || log_rw.size() <= base) begin
            n_err++; $display("[TB] FAIL timeout_done: got no cfg_done required one");
        end else begin
            n_cmp++;
            if ({log_rw[base], done_cyc - log_cyc[base]} !== {1'b0, 32'd51}) begin
                n_err++; $display("[TB] FAIL timeout_latency: got rw=%0b %0d cycles required rw=0 51", log_rw[base], done_cyc - log_cyc[base]);
            end
        end
        wait_polls(poll_done_cnt + 1);
        n_cmp++;
        if (txn_req !== 1'b0) begin
            n_err++; $display("[TB] FAIL timeout_recover: got req=%0b required 0", txn_req);
        end
    endtask

    task automatic test_overrun();
        int t0;
        int base;
        int after = 0;
        for (int n = 0; n < 250 && !(txn_req && txn_rw && (cyc % 100 == 0)); n++) begin
            @(posedge clk); #1;
        end
        eng_ack_delay = 250;
        t0 = cyc;
        base = log_rw.size();
        for (int n = 0; n < 400 && cyc < t0 + 299; n++) begin
            @(posedge clk); #1;
            if (log_rw.size() > base) eng_ack_delay = 0;
            if (cyc == t0 + 150) begin
                n_cmp++;
                if (poll_overrun !== 1'b0) begin
                    n_err++; $display("[TB] FAIL overrun_early: got %0b required 0", poll_overrun);
                end
            end
        end
        eng_ack_delay = 0;
        for (int i = base + 1; i < log_rw.size(); i++)
            if (log_rw[i] && log_cyc[i] <= t0 + 299) after++;
        n_cmp++;
        if ({poll_overrun, log_rw.size() > base, after} !== {1'b1, 1'b1, 32'd1}) begin
            n_err++; $display("[TB] FAIL overrun: got flag=%0b polls_after=%0d required flag=1 polls_after=1", poll_overrun, after);
        end
    endtask

    task automatic test_low_active();
        logic [7:0] pat[6] = '{8'h02, 8'h02, 8'h03, 8'h02, 8'h02, 8'h02};
        int base = poll_done_cnt;
        int p0 = press_cnt;
        low_active = 1'b1;
        for (int i = 0; i < 6; i++) begin
            eng_rdata = pat[i];
            wait_polls(base + i + 1);
            n_cmp++;
            if ({button_0, button_1} !== {(i == 5), 1'b0}) begin
                n_err++; $display("[TB] FAIL low_active_poll%0d: got b0=%0b b1=%0b required b0=%0b b1=0", i, button_0, button_1, (i == 5));
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (press_cnt - p0 !== 1) begin
            n_err++; $display("[TB] FAIL low_active_press: got %0d pulses required 1", press_cnt - p0);
        end
    endtask

    task automatic test_reset_mid();
        eng_ack_delay = 30;
        for (int n = 0; n < 200 && !txn_req; n++) begin
            @(posedge clk); #1;
        end
        repeat (5) @(posedge clk);
        #4 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({txn_req, poll_err, poll_overrun, button_0} !== 4'b0000) begin
            n_err++; $display("[TB] FAIL reset_mid: got req=%0b err=%0b ovr=%0b b0=%0b required all 0",
                              txn_req, poll_err, poll_overrun, button_0);
        end
        eng_ack_delay = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_first_poll();
        test_back_to_back();
        test_poll_nack();
        test_timeout();
        test_overrun();
        test_low_active();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/capsense_poll_sched.md
Name: capsense_poll_sched

Overview:
- Sequences all traffic to the capacitive-sense controller through one shared byte-level I2C transaction engine.
- Issues periodic status-register polls and arbitrates them round-robin against host configuration writes.
- Debounces the two polled button bits and presents level outputs plus press/release pulses.
- Sits between the board user-I/O top level and the I2C transaction engine that drives the cap-sense SCL/SDA pins.

Parameters:
POLL_DIV, 500000, clk cycles between poll ticks (10 ms at 50 MHz); legal range 2 to 2^24-1
DEBOUNCE_CNT, 3, consecutive identical polls required to change a button output; legal range 1-15
STATUS_REG, 8'h03, register address read by each poll
TIMEOUT_CYC, 1000000, cycles in WAIT before a transaction is aborted

Ports:
clk  in  1  50 MHz system clock
reset_n  in  1  asynchronous active-low reset
low_active  in  1  1 = status bits are low-active (inverted before debounce)
cfg_req  in  1  host write request, held until cfg_done
cfg_reg  in  8  host write register address, stable while cfg_req=1
cfg_wdata  in  8  host write data, stable while cfg_req=1
cfg_done  out  1  one-cycle pulse, host write finished
cfg_err  out  1  valid with cfg_done: NACK or timeout
txn_req  out  1  request to I2C engine, held until txn_ack
txn_rw  out  1  1 = read, 0 = write
txn_reg  out  8  register address
txn_wdata  out  8  write data
txn_ack  in  1  one-cycle pulse, engine accepted request
txn_done  in  1  one-cycle pulse, transaction finished
txn_nack  in  1  valid with txn_done: slave NACK
txn_rdata  in  8  valid with txn_done on a read
button_0  out  1  debounced active-high button 0
button_1  out  1  debounced active-high button 1
btn_press  out  2  one-cycle pulse per bit on 0->1
btn_release  out  2  one-cycle pulse per bit on 1->0
poll_overrun  out  1  sticky: tick arrived while a poll was still pending
poll_err  out  1  sticky: poll NACK or timeout

Behaviour:
- Reset values: all outputs 0, FSM IDLE, poll timer 0, poll_pend 0, last_grant = cfg, debounce counters 0.
- Poll timer:
  - Counts 0..POLL_DIV-1 and wraps; the wrap cycle is a tick.
  - Tick sets poll_pend.
  - Tick while poll_pend=1 sets poll_overrun; no second poll is queued.
- FSM:
  - IDLE: if any request (poll_pend or cfg_req), grant; if both, grant the one not equal to last_grant. On grant, latch rw/reg/wdata, update last_grant, clear poll_pend (poll grant), go ISSUE. Grant to ISSUE takes 1 cycle.
  - ISSUE: txn_req=1 with stable fields; on txn_ack, go WAIT and clear the watchdog.
  - WAIT: txn_req=0; on txn_done, go DONE; if the watchdog reaches TIMEOUT_CYC, go DONE with the failure flag set.
  - DONE (1 cycle): complete the owner, return to IDLE.
- cfg completion: pulse cfg_done; cfg_err = txn_nack | timeout. cfg_req must drop the cycle after cfg_done; a still-high cfg_req is treated as a new request.
- Poll completion:
  - On failure: set poll_err; discard the sample; debounce state unchanged.
  - On success: sample = txn_rdata[1:0] XOR {2{low_active}}.
- Debounce, per bit:
  - Sample equal to current output: counter cleared.
  - Sample differs: counter increments; on reaching DEBOUNCE_CNT, output toggles, the press/release pulse fires in the same cycle, counter clears.
- A txn_done outside WAIT is ignored.
- A txn_ack outside ISSUE is ignored.
- low_active change takes effect on the next poll only.
- Reset asserted mid-transaction: immediate return to the reset state, txn_req drops asynchronously. The engine is reset from the same reset_n.

Optional Feature:
CAPSENSE_IRQ_EN:
- Defined: adds ports irq_mask (in, 2), irq_clr (in, 1), irq (out, 1).
  - irq sets on any btn_press or btn_release bit whose irq_mask bit is 1.
  - irq clears on irq_clr; a simultaneous set wins.
  - Reset value 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset, then POLL_DIV=100 with the engine returning rdata=8'h01 (low_active=0) → first txn_req(rw=1, reg=8'h03) 1 cycle after the tick at cycle 99; button_0 rises with btn_press=2'b01 on the 3rd successful poll.
- Both requesters pending at the same time for two grants (cfg_req high, cfg_reg=8'h10, cfg_wdata=8'hA5, concurrent with poll ticks) → grants alternate cfg, poll, cfg; cfg_done pulses with cfg_err=0.
- Engine asserts txn_nack on a poll → poll_err=1; debounce count unchanged; button outputs hold.
- Engine never returns txn_done, TIMEOUT_CYC=50 → DONE at the 50th WAIT cycle; the outstanding cfg request gets cfg_done with cfg_err=1; FSM back in IDLE.
- Engine stalls txn_ack for longer than POLL_DIV → poll_overrun=1; exactly one poll issued after the stall.
- low_active=1, rdata bit0 pattern 0,0,1,0,0,0 → no toggle after 0,0 (count reaches 2 then resets on the 1); button_0 rises on the third consecutive 0; one btn_press pulse.
